// File: rtl/mem_loader.sv
// SAP-1 program loader: takes a framed byte stream (ADDR, LEN, DATA..., CSUM),
// writes the payload into memory and holds the CPU in reset while busy.
module mem_loader #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          acc_q;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                xfer;
  logic                timeout_hit;

  assign xfer        = in_valid && in_ready;
  assign timeout_hit = (state != S_IDLE) && !xfer &&
                       (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_ADDR;
      S_ADDR: if (xfer) state_nx = S_LEN;
      S_LEN:  if (xfer) state_nx = S_DATA;
      S_DATA: if (xfer && cnt_q == CNT_W'(1)) state_nx = S_CSUM;
      S_CSUM: if (xfer) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (timeout_hit) state_nx = S_IDLE;
    if (state != S_IDLE) begin
      in_ready = 1'b1;
      cpu_hold = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      idle_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err      <= 1'b0;
            acc_q    <= '0;
            idle_cnt <= '0;
          end
        end
        S_ADDR: if (xfer) addr_q <= in_data[ADDR_W-1:0];
        S_LEN: begin
          // A length field of zero stands for a full-memory load.
          if (xfer) begin
            if (in_data[ADDR_W-1:0] == '0) cnt_q <= CNT_W'(DEPTH);
            else                           cnt_q <= {1'b0, in_data[ADDR_W-1:0]};
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= in_data;
            acc_q     <= acc_q ^ in_data;
            addr_q    <= addr_q + ADDR_W'(1);
            cnt_q     <= cnt_q - CNT_W'(1);
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == acc_q) done <= 1'b1;
            else                  err  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (state != S_IDLE) begin
        if (xfer) begin
          idle_cnt <= '0;
        end else if (timeout_hit) begin
          err      <= 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: frame-level model predicts writes,
// done/err outcome and memory image; a negedge monitor compares every cycle.
module tb_mem_loader;

  localparam int ADDR_W = 4;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         tag;
  } wr_t;

  wr_t        q[$];
  logic [7:0] shadow[16];
  logic [7:0] pay[16];
  int         done_cnt = 0;

  // Every cycle: writes must appear exactly one cycle after their byte was
  // accepted, in order, and nowhere else.
  always @(negedge clk) begin
    if (done) done_cnt++;
    chk("in_ready_eq_hold", in_ready, cpu_hold);
    if (q.size() > 0 && q[0].tag == cyc) begin
      chk("mem_we", mem_we, 1);
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
      void'(q.pop_front());
    end else begin
      chk("mem_we_quiet", mem_we, 0);
    end
    if (mem_we) shadow[mem_addr] = mem_wdata;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    chk("in_ready_at_byte", in_ready, 1);
    tick();
  endtask

  task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    w.tag = cyc;
    q.push_back(w);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] l,
                           input logic [7:0] cs, input int start_at);
    int         n;
    int         d0;
    logic [7:0] x;
    logic [3:0] wa;
    n  = (l[3:0] == 4'd0) ? 16 : int'(l[3:0]);
    x  = 8'h00;
    wa = a[3:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_after_start", cpu_hold, 1);
    chk("err_cleared_by_start", err, 0);
    d0 = done_cnt;
    send(a);
    send(l);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) start = 1'b1;
      send(pay[i]);
      start = 1'b0;
      push_wr(wa, pay[i]);
      wa = wa + 4'd1;
      x  = x ^ pay[i];
    end
    send(cs);
    in_valid = 1'b0;
    @(negedge clk);
    chk("done", done, cs == x);
    chk("err", err, cs != x);
    chk("hold_released", cpu_hold, 0);
    chk("writes_outstanding", q.size(), 0);
    tick();
    tick();
    chk("done_pulses", done_cnt - d0, (cs == x) ? 1 : 0);
    chk("done_one_cycle", done, 0);
    chk("err_sticky", err, cs != x);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Bytes offered in IDLE are not taken
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int i = 0; i < 5; i++) begin
      chk("idle_in_ready", in_ready, 0);
      chk("idle_cpu_hold", cpu_hold, 0);
      tick();
    end
    in_valid = 1'b0;

    // Reset mid-DATA: second write dropped, outputs cleared at once
    start = 1'b1; tick(); start = 1'b0;
    send(8'h08);
    send(8'h04);
    send(8'h11);
    push_wr(4'd8, 8'h11);
    send(8'h22);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_cpu_hold", cpu_hold, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_mem8", shadow[8], 8'h11);
    chk("midrst_mem9", shadow[9], 8'h00);

    // Basic three-byte frame
    pay[0] = 8'h1E; pay[1] = 8'h2F; pay[2] = 8'hE0;
    run_frame(8'h00, 8'h03, 8'hD1, -1);
    chk("f1_mem0", shadow[0], 8'h1E);
    chk("f1_mem1", shadow[1], 8'h2F);
    chk("f1_mem2", shadow[2], 8'hE0);
    chk("f1_err_lit", err, 0);

    // Full length with address wrap
    for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
    run_frame(8'h0E, 8'h00, 8'h10, -1);
    chk("wrap_mem14", shadow[14], 8'h01);
    chk("wrap_mem15", shadow[15], 8'h02);
    chk("wrap_mem0", shadow[0], 8'h03);
    chk("wrap_mem13", shadow[13], 8'h10);

    // Bad checksum: write stands, err set, no done
    pay[0] = 8'hAA;
    run_frame(8'h05, 8'h01, 8'h55, -1);
    chk("bad_mem5", shadow[5], 8'hAA);
    chk("bad_err_lit", err, 1);

    // Back-to-back payload with a stray start mid-DATA
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h01; pay[3] = 8'h7F;
    run_frame(8'h0A, 8'h04, 8'hE7, 1);
    chk("tp_mem10", shadow[10], 8'h5A);
    chk("tp_mem13", shadow[13], 8'h7F);
    chk("tp_err_lit", err, 0);

    // Timeout after LEN with no further bytes
    start = 1'b1; tick(); start = 1'b0;
    send(8'h03);
    send(8'h02);
    in_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_hold_pending", cpu_hold, 1);
      tick();
    end
    chk("to_hold_released", cpu_hold, 0);
    chk("to_in_ready", in_ready, 0);
    chk("to_err", err, 1);
    tick();
    chk("to_err_sticky", err, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_err_cleared", err, 0);
    for (int i = 0; i < TO + 2; i++) tick();
    chk("to_second_err", err, 1);
    chk("to_writes_outstanding", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader for the SAP-1 16×8 memory: the writer side of the memory that the controller only reads. It accepts a framed byte stream from an external host over a valid/ready byte handshake and writes the payload into memory. It holds the CPU in reset for the duration of the load and verifies an XOR checksum. The block sits between the chip I/O and the memory write port, alongside the `pc`/`controller` path.

## Interface
- `ADDR_W`, 4, memory address width; memory depth is 2^ADDR_W.
- `TIMEOUT`, 1023, idle cycles allowed between accepted bytes before abort; minimum 1.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle request to begin a load; sampled only in IDLE.
- `in_valid` input 1: host byte valid.
- `in_data` input 8: host byte.
- `in_ready` output 1: loader can take a byte; a transfer happens when `in_valid && in_ready` at a rising edge.
- `mem_we` output 1: memory write strobe, one cycle per payload byte.
- `mem_addr` output ADDR_W: write address.
- `mem_wdata` output 8: write data.
- `cpu_hold` output 1: high while busy; OR-ed into the CPU reset.
- `done` output 1: one-cycle pulse when a load finishes with a good checksum.
- `err` output 1: sticky error flag; cleared by the next accepted `start` or by reset.

## Operation
- Frame format, in order:
  - ADDR byte: start address; only the low ADDR_W bits are used.
  - LEN byte: payload count N, using its low ADDR_W bits; 0 means 2^ADDR_W.
  - N DATA bytes.
  - CSUM byte: must equal the XOR of all N DATA bytes.
- States are IDLE → ADDR → LEN → DATA → CSUM → IDLE.
- IDLE:
  - `in_ready`=0 and `cpu_hold`=0.
  - `start`=1 moves to ADDR, clears `err`, and clears the checksum accumulator.
  - Bytes presented in IDLE are not consumed.
- ADDR, LEN, DATA, CSUM: `in_ready`=1 and `cpu_hold`=1.
- ADDR: an accepted byte loads the address counter and moves to LEN.
- LEN: an accepted byte loads the remaining-count counter and moves to DATA.
- DATA: each accepted byte does three things:
  - registers `mem_we`=1, `mem_addr`=current address, `mem_wdata`=byte for the next cycle;
  - XORs the byte into the accumulator;
  - increments the address modulo 2^ADDR_W (15 wraps to 0) and decrements the count.
  - When the count reaches 0, the state moves to CSUM.
- CSUM: an accepted byte is compared with the accumulator.
  - Equal: `done` pulses and the state returns to IDLE.
  - Not equal: `err`=1, no `done`, state returns to IDLE.
  - Memory contents are not rolled back on a checksum error.
- Timeout:
  - In any non-IDLE state, an idle counter increments each cycle with no transfer and clears on each transfer.
  - When it reaches TIMEOUT, `err`=1 and the state returns to IDLE.
  - Writes already issued stand.
- `start` while not in IDLE is ignored.
- The block never stalls the host: back-to-back bytes are accepted every cycle.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE; `in_ready`, `mem_we`, `cpu_hold`, `done`, `err` all 0; `mem_addr`=0; `mem_wdata`=0; counters 0.
- `start` at edge k puts the block in ADDR; `cpu_hold` and `in_ready` go high after edge k.
- Write latency is 1: a DATA byte accepted at edge k presents `mem_we`/`mem_addr`/`mem_wdata` during cycle k..k+1. The memory captures them at edge k+1.
- Outside write cycles, `mem_addr`/`mem_wdata` hold their last values and `mem_we`=0.
- `done` and `err` are registered: they rise in the cycle after the CSUM byte is accepted. `cpu_hold` falls in that same cycle.
- `done` lasts exactly one cycle; `err` holds until the next accepted `start`.
- Minimum frame time is N+3 cycles from the first accepted byte.
- If `rst_n` is asserted mid-load:
  - return to IDLE immediately and release `cpu_hold`;
  - a pending `mem_we` is dropped.

## Test plan
- Reset with `rst_n` low mid-DATA → all outputs 0 at once; next `start` loads normally.
- `start`, then bytes 0x00, 0x03, 0x1E, 0x2F, 0xE0, CSUM 0xD1 → writes mem[0]=0x1E, mem[1]=0x2F, mem[2]=0xE0 on three consecutive cycles; `done` pulses once; `err`=0; `cpu_hold` low afterwards.
- Wrap and full length: ADDR 0x0E, LEN 0x00, 16 bytes 0x01..0x10, correct CSUM 0x10 → writes addresses 14, 15, 0, 1, …, 13; `done`=1.
- Bad checksum: ADDR 0x05, LEN 0x01, DATA 0xAA, CSUM 0x55 → mem[5]=0xAA written; `err`=1; no `done`; next `start` clears `err`.
- Timeout with TIMEOUT=8: send ADDR and LEN, then stop → `err`=1 and state IDLE after 8 idle cycles; no `mem_we`.
- Throughput and ignore rules:
  - `in_valid` held high for a 4-byte payload → one `mem_we` per cycle with `in_ready` never low;
  - `start` pulsed mid-DATA → ignored;
  - bytes offered in IDLE → not consumed.
